// File: rtl/wave_capture_ctrl.sv
// Purpose: arms on a rising zero crossing and writes one frame of scaled samples into the idle half of the capture RAM.
// Latency: one cycle from sample_ready to its RAM write; read_index flips one cycle after the display's idle rising edge.
// Backpressure: none; every sample_ready is accepted, and back-to-back samples give one write per cycle.
module wave_capture_ctrl #(
   parameter int SAMPLE_W = 16,
   parameter int OUT_W    = 8,
   parameter int ADDR_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_ready,
   input  logic [SAMPLE_W-1:0] new_sample,
   input  logic                wave_display_idle,
   output logic                write_enable,
   output logic [ADDR_W:0]     write_address,
   output logic [OUT_W-1:0]    write_sample,
   output logic                read_index,
   output logic                active
);

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   count, count_d;
   logic [SAMPLE_W-1:0] prev_sample;
   logic                idle_q;
   logic                read_index_d;
   logic                write_enable_d;
   logic [ADDR_W:0]     write_address_d;
   logic [OUT_W-1:0]    write_sample_d;

   logic idle_rise;
   logic crossing;
   logic [OUT_W-1:0] scaled;

   assign idle_rise = wave_display_idle & ~idle_q;
   // Negative previous sample followed by a non-negative one (exact zero counts).
   assign crossing  = prev_sample[SAMPLE_W-1] & ~new_sample[SAMPLE_W-1];
   // Top OUT_W bits with the sign flipped: two's complement to offset binary.
   assign scaled    = {~new_sample[SAMPLE_W-1], new_sample[SAMPLE_W-2 -: OUT_W-1]};
   assign active    = (state == ACTIVE);

   // Next-state, frame counter, buffer flip and write strobe decode.
   always_comb begin
      state_d         = state;
      count_d         = count;
      read_index_d    = read_index;
      write_enable_d  = 1'b0;
      write_address_d = write_address;
      write_sample_d  = write_sample;
      case (state)
         ARMED: begin
            if (sample_ready && crossing) begin
               state_d = ACTIVE;
               count_d = '0;
            end
         end
         ACTIVE: begin
            if (sample_ready) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index, count};
               write_sample_d  = scaled;
               count_d         = count + ADDR_W'(1);
               if (count == {ADDR_W{1'b1}}) begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Only a fresh rising edge flips, so the display always draws a whole frame from the old half.
            if (idle_rise) begin
               read_index_d = ~read_index;
               state_d      = ARMED;
            end
         end
         default: begin
            state_d = ARMED;
         end
      endcase
   end

   // State, counter, buffer index and registered RAM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ARMED;
         count         <= '0;
         read_index    <= 1'b0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_sample  <= '0;
      end else begin
         state         <= state_d;
         count         <= count_d;
         read_index    <= read_index_d;
         write_enable  <= write_enable_d;
         write_address <= write_address_d;
         write_sample  <= write_sample_d;
      end
   end

   // Sample history for crossing detection and display idle edge history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_sample <= '0;
         idle_q      <= 1'b0;
      end else begin
         idle_q <= wave_display_idle;
         if (sample_ready) begin
            prev_sample <= new_sample;
         end
      end
   end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Purpose: directed checks of trigger, frame writes, buffer flip, WAIT behaviour and async reset.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: not applicable; the bench drives sample_ready freely.
module tb_wave_capture_ctrl;

   logic        clk;
   logic        reset;
   logic        sample_ready;
   logic [15:0] new_sample;
   logic        wave_display_idle;
   logic        write_enable;
   logic [8:0]  write_address;
   logic [7:0]  write_sample;
   logic        read_index;
   logic        active;

   int checks = 0;
   int errors = 0;

   wave_capture_ctrl #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .sample_ready      (sample_ready),
      .new_sample        (new_sample),
      .wave_display_idle (wave_display_idle),
      .write_enable      (write_enable),
      .write_address     (write_address),
      .write_sample      (write_sample),
      .read_index        (read_index),
      .active            (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] v);
      sample_ready = 1'b1;
      new_sample   = v;
      tick();
      sample_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},  32'(write_enable),  32'h0);
      chk({tag, "_adr"}, 32'(write_address), 32'h0);
      chk({tag, "_dat"}, 32'(write_sample),  32'h0);
      chk({tag, "_ri"},  32'(read_index),    32'h0);
      chk({tag, "_act"}, 32'(active),        32'h0);
   endtask

   initial begin
      reset             = 1'b1;
      sample_ready      = 1'b0;
      new_sample        = 16'h0000;
      wave_display_idle = 1'b0;
      #1;
      chk_all_zero("rst");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Trigger on -5 -> +3; +3 itself is not written.
      send(16'hFFFB);
      chk("pre_trig_act", 32'(active), 32'h0);
      send(16'h0003);
      chk("trig_act", 32'(active), 32'h1);
      chk("trig_we",  32'(write_enable), 32'h0);
      chk("trig_ri",  32'(read_index), 32'h0);

      // Full back-to-back frame into the upper half; idle goes high before WAIT is entered.
      wave_display_idle = 1'b1;
      sample_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         new_sample = 16'(i << 8);
         tick();
         chk("f1_we",  32'(write_enable), 32'h1);
         chk("f1_adr", 32'(write_address), 32'(9'h100 + i));
         chk("f1_dat", 32'(write_sample), 32'((i ^ 8'h80) & 8'hFF));
         chk("f1_act", 32'(active), (i == 255) ? 32'h0 : 32'h1);
      end
      sample_ready = 1'b0;
      tick();
      chk("f1_we_end", 32'(write_enable), 32'h0);

      // WAIT with idle held high: no flip; crossings ignored.
      tick();
      tick();
      chk("wait_hold_ri", 32'(read_index), 32'h0);
      send(16'hFFFC);
      send(16'h0002);
      chk("wait_x_we",  32'(write_enable), 32'h0);
      chk("wait_x_act", 32'(active), 32'h0);
      send(16'hFFF9);
      wave_display_idle = 1'b0;
      tick();
      chk("wait_low_ri", 32'(read_index), 32'h0);
      // Idle rises in the same cycle as a crossing: flip happens, crossing is not a trigger.
      wave_display_idle = 1'b1;
      send(16'h0001);
      chk("flip_ri",  32'(read_index), 32'h1);
      chk("flip_act", 32'(active), 32'h0);
      chk("flip_we",  32'(write_enable), 32'h0);

      // Exact zero after a negative sample triggers.
      send(16'hFFFE);
      chk("re_pre_act", 32'(active), 32'h0);
      send(16'h0000);
      chk("re_trig_act", 32'(active), 32'h1);

      // Second frame targets the lower half; reset asynchronously after 100 writes.
      sample_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         new_sample = 16'((i << 8) | 16'h0055);
         tick();
         chk("f2_we",  32'(write_enable), 32'h1);
         chk("f2_adr", 32'(write_address), 32'(i));
         chk("f2_dat", 32'(write_sample), 32'((i ^ 8'h80) & 8'hFF));
      end
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("arst");
      sample_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_rst_ri", 32'(read_index), 32'h0);

      // Positive-only and 0 -> 0 do not trigger.
      send(16'h000A);
      send(16'h0014);
      send(16'h0000);
      send(16'h0000);
      chk("pos_only_act", 32'(active), 32'h0);
      send(16'hFFFD);
      send(16'h0000);
      chk("rst_trig_act", 32'(active), 32'h1);
      send(16'h1234);
      chk("rst_f_we",  32'(write_enable), 32'h1);
      chk("rst_f_adr", 32'(write_address), 32'h100);
      chk("rst_f_dat", 32'(write_sample), 32'h92);
      tick();
      chk("rst_f_we_end", 32'(write_enable), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
